// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register-file writeback arbiter.
//   - Default data/address widths and register count.
//   - Controller state encoding {CLEAR, RUN}.
//   - Requester index constants (mem, alu, dbg) and a modulo-3 increment helper.
package rf_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_REGS = 32;
    localparam int RF_NUM_REQ  = 3;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    localparam logic [1:0] REQ_MEM = 2'd0;
    localparam logic [1:0] REQ_ALU = 2'd1;
    localparam logic [1:0] REQ_DBG = 2'd2;

    // Next requester index in round-robin order, wrapping dbg -> mem.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == REQ_DBG) ? REQ_MEM : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: three-way round-robin arbiter.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              arbitration allowed this cycle (no grants when low)
//   valid[2:0]      request lines
//   grant[2:0]      one-hot grant (combinational)
//   grant_idx[1:0]  index of the granted requester (meaningful when any_grant)
//   any_grant       a grant is being given this cycle
// The search starts at the pointer and wraps modulo 3; after a grant the
// pointer moves to the requester just past the winner, otherwise it holds.
module rr_arbiter3
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] valid,
    output logic [2:0] grant,
    output logic [1:0] grant_idx,
    output logic       any_grant
);

    logic [1:0] ptr_reg;
    logic [1:0] ptr_next;
    logic [1:0] scan_idx;

    always_comb begin
        grant     = 3'b000;
        grant_idx = ptr_reg;
        any_grant = 1'b0;
        scan_idx  = ptr_reg;
        for (int k = 0; k < RF_NUM_REQ; k++) begin
            if (en && !any_grant && valid[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                grant_idx       = scan_idx;
                any_grant       = 1'b1;
            end
            scan_idx = rr_next(scan_idx);
        end
    end

    assign ptr_next = any_grant ? rr_next(grant_idx) : ptr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= REQ_MEM;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: owns the register-file write port, sharing it among
// the mem (0), alu (1) and dbg (2) writeback requesters via round-robin,
// and runs a clear sweep that zeroes every register after reset (optional)
// or on clr_req.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready[2:0]    per-requester handshake (ready is one-hot)
//   req_addr/req_data           packed per requester, slot i at [i*W +: W]
//   clr_req                     pulse: start a clear sweep (ignored while clearing)
//   busy                        high while the sweep owns the port
//   clear_done                  one-cycle pulse in the first cycle back in RUN
//   wr_en/wr_addr/wr_data       registered register-file write port
// Optional feature: define RF_BYPASS_EN to add read-forwarding ports
//   rs/rt, rf_in1/rf_in2 -> rs_data/rt_data.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W       = RF_DATA_W,
    parameter int ADDR_W       = RF_ADDR_W,
    parameter int NUM_REGS     = RF_NUM_REGS,
    parameter int CLR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req_valid,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [3*DATA_W-1:0]   req_data,
    output logic [2:0]            req_ready,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  clear_done,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data
`ifdef RF_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]     rs,
    input  logic [ADDR_W-1:0]     rt,
    input  logic [DATA_W-1:0]     rf_in1,
    input  logic [DATA_W-1:0]     rf_in2,
    output logic [DATA_W-1:0]     rs_data,
    output logic [DATA_W-1:0]     rt_data
`endif
);

    localparam logic [0:0] S_CLEAR = CLEAR;
    localparam logic [0:0] S_RUN   = RUN;
    localparam logic [0:0] S_INIT  = (CLR_ON_RESET != 0) ? S_CLEAR : S_RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    logic [0:0]        state_reg;
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [DATA_W-1:0] wr_data_reg;
    logic              clear_done_reg;

    logic [ADDR_W-1:0] addr_arr [0:2];
    logic [DATA_W-1:0] data_arr [0:2];
    logic [1:0]        grant_idx;
    logic              any_grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    genvar gi;
    generate
        for (gi = 0; gi < RF_NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Gating the arbiter with the state keeps req_ready low during a sweep
    // and freezes the pointer while the sequencer owns the port.
    rr_arbiter3 u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (state_reg == S_RUN),
        .valid     (req_valid),
        .grant     (req_ready),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign sel_addr = addr_arr[grant_idx];
    assign sel_data = data_arr[grant_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_INIT;
            clr_cnt_reg    <= '0;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            clear_done_reg <= 1'b0;
        end else begin
            wr_en_reg      <= 1'b0;
            clear_done_reg <= 1'b0;
            if (state_reg == S_CLEAR) begin
                wr_en_reg   <= 1'b1;
                wr_addr_reg <= clr_cnt_reg;
                wr_data_reg <= '0;
                if (clr_cnt_reg == LAST_ADDR) begin
                    state_reg      <= S_RUN;
                    clear_done_reg <= 1'b1;
                    clr_cnt_reg    <= '0;
                end else begin
                    clr_cnt_reg <= clr_cnt_reg + 1'b1;
                end
            end else begin
                if (any_grant) begin
                    // Register 0 is hardwired to zero: accept, but do not write.
                    wr_en_reg   <= (sel_addr != '0);
                    wr_addr_reg <= sel_addr;
                    wr_data_reg <= sel_data;
                end
                // This cycle's grant is still issued above; the sweep starts next cycle.
                if (clr_req) begin
                    state_reg <= S_CLEAR;
                end
            end
        end
    end

    assign wr_en      = wr_en_reg;
    assign wr_addr    = wr_addr_reg;
    assign wr_data    = wr_data_reg;
    assign clear_done = clear_done_reg;
    assign busy       = (state_reg == S_CLEAR);

`ifdef RF_BYPASS_EN
    // Forward the write in flight so a same-cycle read sees the new value.
    assign rs_data = (wr_en_reg && (wr_addr_reg == rs) && (rs != '0)) ? wr_data_reg : rf_in1;
    assign rt_data = (wr_en_reg && (wr_addr_reg == rt) && (rt != '0)) ? wr_data_reg : rf_in2;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

- Owns the single write port of `register_file` and shares it among three writeback requesters: memory load, ALU result and debug host.
- Uses a round-robin arbiter with valid/ready handshakes.
- Runs a clear sequencer that zeroes every register after reset or on command.
- Sits between the execute/memory stages and `register_file`; drives its `rd` and `out` inputs plus a write enable.

## Interface
- `DATA_W`, 32, data width.
- `ADDR_W`, 5, register address width.
- `NUM_REGS`, 32, registers cleared by the sequencer (≤ 2^ADDR_W).
- `CLR_ON_RESET`, 1, 1 = run a clear sweep after reset; 0 = enter RUN directly.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  clock.
  - `rst`  in  1  reset.
- Requesters, index i: 0 = mem, 1 = alu, 2 = dbg.
  - `req_valid`  in  3  per-requester write request.
  - `req_addr`  in  3×ADDR_W  packed destination register, requester i at bits [i*ADDR_W +: ADDR_W].
  - `req_data`  in  3×DATA_W  packed write data, same packing.
  - `req_ready`  out  3  one-hot accept; transfer when valid & ready.
- Clear control and status:
  - `clr_req`  in  1  single-cycle pulse starting a clear sweep.
  - `busy`  out  1  high while in CLEAR.
  - `clear_done`  out  1  one-cycle pulse when a sweep completes.
- Register-file write port:
  - `wr_en`  out  1  write enable to the register file.
  - `wr_addr`  out  ADDR_W  drives `register_file.rd`.
  - `wr_data`  out  DATA_W  drives `register_file.out`.
- Bypass ports, present only with `RF_BYPASS_EN`:
  - `rs`, `rt`  in  ADDR_W  read addresses.
  - `rf_in1`, `rf_in2`  in  DATA_W  raw read data from the register file.
  - `rs_data`, `rt_data`  out  DATA_W  forwarded read data.

## Operation
- **States**
  - CLEAR: sequencer owns the port.
  - RUN: arbiter owns the port.
- **Reset values**
  - State = CLEAR if `CLR_ON_RESET` else RUN.
  - `clr_cnt` = 0; rr pointer = 0.
  - `wr_en`/`wr_addr`/`wr_data` = 0; `req_ready` = 0; `clear_done` = 0.
  - `busy` = `CLR_ON_RESET`.
- **CLEAR**
  - Each cycle registers wr_en=1, wr_addr=clr_cnt, wr_data=0, then clr_cnt++.
  - When clr_cnt == NUM_REGS-1 is issued: go to RUN, pulse `clear_done`, reset clr_cnt to 0.
  - `req_ready` = 0 throughout CLEAR.
- **RUN arbitration (combinational)**
  - Search from the rr pointer upward, modulo 3.
  - The first requester with valid=1 gets ready=1; all others get 0.
  - On a transfer the pointer becomes (granted+1) mod 3.
  - With no valid request, the pointer holds.
- **Write issue**
  - A transfer registers wr_en=1, wr_addr=req_addr[g], wr_data=req_data[g].
  - A transfer to address 0 is accepted but registers wr_en=0; the pointer still advances.
- **clr_req**
  - In RUN: the current-cycle grant is still honoured; CLEAR is entered next cycle.
  - In CLEAR: ignored; the sweep is not restarted.
- **Holding requests**
  - Requesters hold valid/addr/data stable until ready.

## Timing
- Write latency: transfer at edge N → wr_en/wr_addr/wr_data valid during cycle N+1; the register file captures at edge N+2.
- Throughput: one write per cycle; each valid requester is granted within 3 cycles.
- Clear sweep:
  - Exactly NUM_REGS consecutive wr_en cycles.
  - `clear_done` is coincident with the first RUN cycle.
  - `busy` drops in that same cycle.
- rst asserted mid-sweep: outputs clear immediately; the sweep restarts from address 0 after release.
- rst asserted mid-write: the pending wr_en is dropped.
- clr_req and a request in the same cycle: the request is granted, then CLEAR starts.

## Configuration
- `RF_BYPASS_EN` defined:
  - `rs_data` = `wr_data` when wr_en && wr_addr == rs && rs != 0; otherwise `rf_in1`.
  - `rt_data` follows the same rule using `rt` and `rf_in2`.
- `RF_BYPASS_EN` undefined:
  - Bypass ports are absent.
  - Reads go straight from `register_file.in1`/`in2`.

## Structure
- Shared package `rf_pkg`:
  - `ADDR_W`, `DATA_W`, `NUM_REGS` defaults.
  - State enum {CLEAR, RUN}.
  - Requester index constants `REQ_MEM`/`REQ_ALU`/`REQ_DBG`.
- Sub-module `rr_arbiter3`: combinational grant plus pointer register; the top holds the FSM, clear counter and output registers.

## Test plan
- **Reset sweep:** CLR_ON_RESET=1, release rst → wr_addr walks 0..31 with wr_data=0 for 32 cycles, `clear_done` pulses once, `busy` falls.
- **Single write:** ALU valid, addr=3, data=32'hAAAAAAAA → ready in cycle N, wr_en=1, addr 3 in N+1; register_file.in1 reads AAAAAAAA with rs=3.
- **Round-robin fairness:** all three valid continuously → grants cycle mem, alu, dbg, mem…
- **Address 0 suppression:** dbg writes addr 0, data 5 → ready=1, wr_en stays 0, pointer advances.
- **Mid-sweep clear:** clr_req while alu is valid → alu granted, then 32 clear writes with ready=0; rst pulse mid-sweep restarts at address 0.
- **Forwarding:** with RF_BYPASS_EN, rs=7 while wr_addr=7, wr_data=0x1234 → rs_data=0x1234; with rs=0 → rs_data=rf_in1.
